// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: bubble encoding, major opcodes and the IF/ID record.
package riscv_pipe_pkg;

  localparam logic [31:0] RV_NOP  = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0]  OPC_LD  = 7'b0000011;
  localparam logic [6:0]  OPC_SD  = 7'b0100011;
  localparam logic [6:0]  OPC_BEQ = 7'b1100011;
  localparam logic [6:0]  OPC_ALU = 7'b0110011;

  typedef struct packed {
    logic [31:0] ir;
    logic [63:0] pc;
    logic        valid;
  } ifid_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  // A bubble keeps the old pc so downstream debug views stay meaningful.
  function automatic ifid_t ifid_bubble(input logic [31:0] nop, input logic [63:0] pc);
    ifid_t b;
    b.ir    = nop;
    b.pc    = pc;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small prefetch FIFO of {pc, ir}; flush beats push in the same cycle.
module fetch_buffer
  import riscv_pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  entries [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Qualify push/pop: flush cancels both, a full buffer only accepts alongside a pop.
  always_comb begin
    do_pop  = pop && !flush && (count_q != '0);
    do_push = push && !flush && ((count_q < CW'(DEPTH)) || do_pop);
  end

  // Pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy alone says what is live.
  always_ff @(posedge clock) begin
    if (do_push) entries[wr_ptr_q] <= push_data;
  end

  assign head  = entries[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/riscv_fetch_stage.sv
// Instruction fetch: owns the PC, drives a sync-read IMEM, buffers across decode
// stalls and loads the IF/ID register; redirects flush all wrong-path state.
module riscv_fetch_stage
  import riscv_pipe_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter int          BUF_DEPTH  = 2,
  parameter logic [31:0] NOP_INSN   = RV_NOP,
  parameter int          AW         = $clog2(IMEM_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect,
  input  logic [63:0]   redirect_pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   ifid_ir,
  output logic [63:0]   ifid_pc,
  output logic          ifid_valid
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [63:0]   pc_q;
  logic          inflight_valid_q;
  logic [63:0]   inflight_pc_q;
  ifid_t         ifid_q, ifid_next;

  fetch_entry_t  buf_head, buf_push_data;
  logic [CW-1:0] buf_count;
  logic          buf_empty, buf_push, buf_pop;
  logic          issue, resp_direct;
  logic [CW:0]   credit_used, credit_cap;

  // Credit check: never fetch more than the buffer (plus a draining IF/ID) can hold.
  always_comb begin
    credit_used = {1'b0, buf_count} + {{CW{1'b0}}, inflight_valid_q};
    credit_cap  = (CW+1)'(BUF_DEPTH) + {{CW{1'b0}}, !stall};
    issue       = !reset && !redirect && (credit_used < credit_cap);
    resp_direct = inflight_valid_q && buf_empty && !stall;
    buf_push    = inflight_valid_q && !resp_direct;
    buf_pop     = !stall && !buf_empty;
    buf_push_data.pc = inflight_pc_q;
    buf_push_data.ir = imem_rdata;
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (buf_push),
    .push_data (buf_push_data),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count),
    .empty     (buf_empty)
  );

  // Next IF/ID: redirect bubbles, stall holds, else oldest instruction available.
  always_comb begin
    ifid_next = ifid_q;
    if (redirect) begin
      ifid_next = ifid_bubble(NOP_INSN, ifid_q.pc);
    end else if (!stall) begin
      if (!buf_empty) begin
        ifid_next.ir    = buf_head.ir;
        ifid_next.pc    = buf_head.pc;
        ifid_next.valid = 1'b1;
      end else if (inflight_valid_q) begin
        ifid_next.ir    = imem_rdata;
        ifid_next.pc    = inflight_pc_q;
        ifid_next.valid = 1'b1;
      end else begin
        ifid_next = ifid_bubble(NOP_INSN, ifid_q.pc);
      end
    end
  end

  // PC, in-flight slot and IF/ID register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q             <= '0;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      ifid_q           <= ifid_bubble(NOP_INSN, 64'd0);
    end else begin
      if (redirect)   pc_q <= redirect_pc & ~64'd3;
      else if (issue) pc_q <= pc_q + 64'd4;
      inflight_valid_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
      ifid_q <= ifid_next;
    end
  end

  assign imem_req   = issue;
  assign imem_addr  = pc_q[AW+1:2];
  assign ifid_ir    = ifid_q.ir;
  assign ifid_pc    = ifid_q.pc;
  assign ifid_valid = ifid_q.valid;

endmodule

// File: doc/riscv_fetch_stage.md
# riscv_fetch_stage

Instruction-fetch stage of the five-stage RISC-V pipeline. It owns the PC and drives a synchronous-read instruction memory. It absorbs decode stalls in a small prefetch buffer and loads the IF/ID pipeline register consumed by the decode/register-read stage. Branch redirects flush all wrong-path state and insert NOP bubbles.

## Interface
- `IMEM_WORDS`, default 1024: instruction memory depth in 32-bit words; index = PC[log2(IMEM_WORDS)+1:2].
- `BUF_DEPTH`, default 2: prefetch buffer entries.
- `NOP_INSN`, default 32'h0000_0013: bubble encoding (addi x0,x0,0).
- `clock`  in  1  single clock, all state on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `stall`  in  1  hazard unit: hold IF/ID this cycle.
- `redirect`  in  1  taken branch/jump: flush and refetch.
- `redirect_pc`  in  64  target; bits [1:0] ignored (forced 0).
- `imem_req`  out  1  read strobe this cycle.
- `imem_addr`  out  log2(IMEM_WORDS)  word index.
- `imem_rdata`  in  32  word for the request issued the previous cycle.
- `ifid_ir`  out  32  IF/ID instruction register.
- `ifid_pc`  out  64  PC of `ifid_ir`.
- `ifid_valid`  out  1  1 = real instruction, 0 = bubble.

## Operation
- State: `pc_q` (next fetch PC), one in-flight slot {valid, pc}, buffer of BUF_DEPTH {pc, ir}, IF/ID register.
- Issue: `imem_req`=1, `imem_addr`=`pc_q` index when occupancy + inflight < BUF_DEPTH + (IF/ID will drain this cycle ? 1 : 0), and redirect=0. On issue, `pc_q` += 4. 64-bit wrap is modulo 2^64. The memory index wraps modulo IMEM_WORDS.
- Response: when the in-flight slot is valid, `imem_rdata` is the instruction for the slot's pc. It goes straight to IF/ID if the buffer is empty and stall=0; otherwise it is pushed into the buffer.
- IF/ID update, stall=0: load the buffer head if non-empty, else the arriving response, else NOP_INSN with valid=0 and pc unchanged.
- IF/ID update, stall=1: hold IF/ID; responses push into the buffer. The credit rule guarantees no overflow.
- Redirect (priority over stall and everything else):
  - `pc_q` <= redirect_pc & ~3.
  - Buffer cleared; in-flight response discarded.
  - IF/ID <= NOP_INSN, valid=0.
  - No issue in the redirect cycle.
- Ordering: instructions reach IF/ID in strict program order, none dropped or duplicated except on redirect flush.

## Timing
- Reset values: `pc_q`=0, buffer empty, inflight=0, `imem_req`=0, `ifid_ir`=NOP_INSN, `ifid_pc`=0, `ifid_valid`=0.
- After reset release, the cycle numbering is:
  - cycle 0: issue PC 0.
  - cycle 1: rdata arrives.
  - cycle 2: IF/ID shows PC 0, valid=1.
  - Thereafter one instruction per cycle with no bubbles while stall=0.
- Redirect penalty, redirect in cycle t:
  - cycles t+1 and t+2: IF/ID is a bubble.
  - cycle t+1: target issued.
  - cycle t+3: target in IF/ID.
- Stall released in cycle s: the buffered instruction appears in IF/ID in cycle s+1. The buffer then drains one per cycle while refill continues.
- Reset asserted mid-operation: all outputs take reset values asynchronously. Any in-flight response is ignored. Fetch restarts at PC 0 as from power-up.
- Redirect and stall in the same cycle: redirect wins; IF/ID becomes a bubble.
- Redirect while the buffer is full: the buffer is emptied in one cycle.

## Structure
- Shared package `riscv_pipe_pkg`, holding:
  - NOP constant and opcode constants (LD, SD, BEQ, ALUop).
  - A typedef for the IF/ID record {ir[31:0], pc[63:0], valid}.
  - The `ifid` outputs are a flattened view of that record.
- Sub-module `fetch_buffer`: parameterised BUF_DEPTH FIFO of {pc, ir} with push, pop, flush and count. Flush has priority over push in the same cycle.

## Test plan
- Reset, then run with stall=0 on IMEM holding word i = i: `ifid_pc` = 0, 4, 8, … from cycle 2; `ifid_ir` = 0, 1, 2; valid=1 each cycle.
- stall=1 for 3 cycles while IF/ID holds PC 8: IF/ID holds PC 8 throughout, `imem_req` drops after two issues, no overflow. After release: PC 12, 16, 20 on consecutive cycles, no gap or repeat.
- redirect=1, redirect_pc=0x103 at cycle t: bubbles (valid=0, ir=0x13) at t+1 and t+2; cycle t+3 shows `ifid_pc`=0x100 with ir = word 64.
- redirect and stall together while the buffer is full: IF/ID becomes a bubble next cycle, the buffer is empty, and the next valid instruction comes from the target.
- PC wrap: redirect_pc=4092 with IMEM_WORDS=1024 gives word 1023 then PC 4096 → index 0. Redirect_pc=64'hFFFF_FFFF_FFFF_FFFC gives next `ifid_pc`=0.
- Assert reset at a random cycle mid-stream: outputs take reset values immediately; after release, `ifid_pc`=0 appears two cycles later and the stale response never reaches IF/ID.
